// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and ALU operations.
// The datapath and the testbench import the same definitions.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_SW  = 3'b001,
        OP_BEQ = 3'b010,
        OP_BLT = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_AND = 3'b110,
        OP_OR  = 3'b111
    } opcode_t;

    // Codes 10-15 are unused and recover to S_IDLE.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/multicycle_controller_decode.sv
// Combinational control decode: maps the current state and the captured opcode to the datapath strobes.
// Illegal state codes decode to all-zero outputs.
module controller_decode
    import multicycle_controller_pkg::*;
(
    input  state_t      state,
    input  opcode_t     opcode,
    input  logic        alu_zero,
    input  logic        alu_lt,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        busy
);

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        busy       = 1'b0;
        case (state)
            S_IDLE: ;
            S_FETCH: begin
                busy     = 1'b1;
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: busy = 1'b1;
            S_MEM_ADDR: begin
                busy    = 1'b1;
                alu_src = 1'b1;
            end
            S_MEM_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                busy      = 1'b1;
                mem_write = 1'b1;
            end
            // ALU opcodes carry the operation in their low two bits.
            S_EXECUTE: begin
                busy   = 1'b1;
                alu_op = opcode[1:0];
            end
            S_ALU_WB: begin
                busy      = 1'b1;
                alu_op    = opcode[1:0];
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                busy     = 1'b1;
                alu_op   = ALU_SUB;
                pc_src   = 1'b1;
                pc_write = (opcode == OP_BLT) ? alu_lt : alu_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU controller: state register, captured opcode and retired-instruction counter.
// run is a level enable: it is sampled at IDLE and at each retire state, so an in-flight instruction always completes.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [15:0] INSTR_LIMIT = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [2:0]  opcode,
    input  logic        alu_zero,
    input  logic        alu_lt,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        busy,
    output logic [15:0] instr_count,
    output logic        done
);

    state_t      state_q;
    opcode_t     opcode_q;
    logic [15:0] count_q;
    logic        done_q;
    logic        halted_q;

    logic [15:0] count_next;
    logic        limit_hit;

    assign count_next = count_q + 16'd1;
    assign limit_hit  = (INSTR_LIMIT != 16'd0) && (count_next == INSTR_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opcode_q <= OP_LW;
            count_q  <= 16'd0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Once the limit is reached only reset can restart sequencing.
                    if (run && !halted_q) state_q <= S_FETCH;
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    opcode_q <= opcode_t'(opcode);
                    if (opcode[2])                state_q <= S_EXECUTE;
                    else if (opcode[1:0] == 2'b00 || opcode[1:0] == 2'b01)
                        state_q <= (opcode[1]) ? S_BRANCH : S_MEM_ADDR;
                    else                          state_q <= S_BRANCH;
                end
                S_MEM_ADDR: state_q <= (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ: state_q <= S_MEM_WB;
                S_EXECUTE:  state_q <= S_ALU_WB;
                S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH: begin
                    count_q <= count_next;
                    done_q  <= limit_hit;
                    if (limit_hit) halted_q <= 1'b1;
                    state_q <= (run && !limit_hit) ? S_FETCH : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    controller_decode u_decode (
        .state      (state_q),
        .opcode     (opcode_q),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .busy       (busy)
    );

    assign state       = state_q;
    assign instr_count = count_q;
    assign done        = done_q;

endmodule
